// File: rtl/bus_arbiter_pkg.sv
// Shared types and constants for the round-robin bus arbiter.
package bus_arbiter_pkg;

  localparam int unsigned NUM_SRC = 4;
  localparam int unsigned IDX_W   = 2;
  localparam int unsigned BURST_W = 4;
  localparam int unsigned DATA_W  = 4;

  localparam logic [IDX_W-1:0] SRC_A = 2'd0;
  localparam logic [IDX_W-1:0] SRC_B = 2'd1;
  localparam logic [IDX_W-1:0] SRC_C = 2'd2;
  localparam logic [IDX_W-1:0] SRC_D = 2'd3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } state_t;

endpackage

// File: rtl/bus_arbiter_mux4x1.sv
// One-bit 4:1 gate-level mux; s1/s0 select d0..d3.
module mux4x1 (
  input  logic i_s1,
  input  logic i_s0,
  input  logic i_d0,
  input  logic i_d1,
  input  logic i_d2,
  input  logic i_d3,
  output logic o_y_c
);

  assign o_y_c = (~i_s1 & ~i_s0 & i_d0) |
                 (~i_s1 &  i_s0 & i_d1) |
                 ( i_s1 & ~i_s0 & i_d2) |
                 ( i_s1 &  i_s0 & i_d3);

endmodule

// File: rtl/bus_arbiter_rr_picker.sv
// Round-robin search: first set request strictly after i_last, wrapping back to i_last itself.
module rr_picker
  import bus_arbiter_pkg::*;
(
  input  logic [NUM_SRC-1:0] i_req,
  input  logic [IDX_W-1:0]   i_last,
  output logic [NUM_SRC-1:0] o_win_c,
  output logic [IDX_W-1:0]   o_idx_c,
  output logic               o_any_c
);

  logic [IDX_W-1:0] w_cand;

  always_comb begin
    o_win_c = '0;
    o_idx_c = '0;
    o_any_c = 1'b0;
    w_cand  = '0;
    // Offset NUM_SRC wraps to i_last, so the last holder only wins when it is alone.
    for (int unsigned k = 1; k <= NUM_SRC; k++) begin
      w_cand = i_last + IDX_W'(k);
      if (!o_any_c && i_req[w_cand]) begin
        o_any_c = 1'b1;
        o_idx_c = w_cand;
        o_win_c = NUM_SRC'(1) << w_cand;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Four-source round-robin bus arbiter with per-grant burst limit and muxed data output.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int unsigned MAX_BURST = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] req,
  input  logic [DATA_W-1:0]  registerA,
  input  logic [DATA_W-1:0]  registerB,
  input  logic [DATA_W-1:0]  registerC,
  input  logic [DATA_W-1:0]  registerD,
  output logic [NUM_SRC-1:0] gnt,
  output logic               select_x,
  output logic               select_y,
  output logic               bus_valid,
  output logic [DATA_W-1:0]  out
);

  localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(MAX_BURST - 1);

  state_t               r_state, w_state_nxt;
  logic [NUM_SRC-1:0]   r_gnt,   w_gnt_nxt;
  logic [IDX_W-1:0]     r_sel,   w_sel_nxt;
  logic [IDX_W-1:0]     r_last,  w_last_nxt;
  logic [BURST_W-1:0]   r_burst, w_burst_nxt;
  logic                 r_valid;
  logic                 w_hold_end;
  logic [NUM_SRC-1:0]   w_win;
  logic [IDX_W-1:0]     w_win_idx;
  logic                 w_win_any;
  logic [DATA_W-1:0]    w_mux;

  rr_picker u_picker (
    .i_req   (req),
    .i_last  (r_last),
    .o_win_c (w_win),
    .o_idx_c (w_win_idx),
    .o_any_c (w_win_any)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_gnt   <= '0;
      r_sel   <= SRC_A;
      r_last  <= SRC_D;
      r_burst <= '0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_sel   <= w_sel_nxt;
      r_last  <= w_last_nxt;
      r_burst <= w_burst_nxt;
      r_valid <= |w_gnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_sel_nxt   = r_sel;
    w_last_nxt  = r_last;
    w_burst_nxt = r_burst;
    w_hold_end  = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_win_any) begin
          w_state_nxt = ST_XFER;
          w_gnt_nxt   = w_win;
          w_sel_nxt   = w_win_idx;
          w_last_nxt  = w_win_idx;
          w_burst_nxt = '0;
        end
      end
      ST_XFER: begin
        w_hold_end = !req[r_sel] || (r_burst == BURST_LAST);
        // Picker excludes the holder unless it is the sole requester, covering re-grant.
        if (!w_hold_end) begin
          w_burst_nxt = r_burst + BURST_W'(1);
        end else if (w_win_any) begin
          w_gnt_nxt   = w_win;
          w_sel_nxt   = w_win_idx;
          w_last_nxt  = w_win_idx;
          w_burst_nxt = '0;
        end else begin
          w_state_nxt = ST_IDLE;
          w_gnt_nxt   = '0;
          w_sel_nxt   = SRC_A;
          w_burst_nxt = '0;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_gnt_nxt   = '0;
        w_sel_nxt   = SRC_A;
        w_burst_nxt = '0;
      end
    endcase
  end

  for (genvar b = 0; b < DATA_W; b++) begin : g_mux
    mux4x1 u_mux (
      .i_s1  (r_sel[1]),
      .i_s0  (r_sel[0]),
      .i_d0  (registerA[b]),
      .i_d1  (registerB[b]),
      .i_d2  (registerC[b]),
      .i_d3  (registerD[b]),
      .o_y_c (w_mux[b])
    );
  end

  assign gnt       = r_gnt;
  assign select_x  = r_sel[1];
  assign select_y  = r_sel[0];
  assign bus_valid = r_valid;
  assign out       = w_mux & {DATA_W{r_valid}};

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: one instance with MAX_BURST=4, one with MAX_BURST=2.
module tb_bus_arbiter;

  typedef struct {
    logic [3:0] g4;
    logic [3:0] o4;
    logic [3:0] g2;
    logic [3:0] o2;
    string      nm;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] req = 4'b0000;
  logic [3:0] reg_a = 4'h1, reg_b = 4'h2, reg_c = 4'h4, reg_d = 4'h8;

  logic [3:0] gnt4, out4, gnt2, out2;
  logic       sx4, sy4, bv4, sx2, sy2, bv2;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  bus_arbiter #(.MAX_BURST(4)) u_dut4 (
    .clk(clk), .reset(reset), .req(req),
    .registerA(reg_a), .registerB(reg_b), .registerC(reg_c), .registerD(reg_d),
    .gnt(gnt4), .select_x(sx4), .select_y(sy4), .bus_valid(bv4), .out(out4)
  );

  bus_arbiter #(.MAX_BURST(2)) u_dut2 (
    .clk(clk), .reset(reset), .req(req),
    .registerA(reg_a), .registerB(reg_b), .registerC(reg_c), .registerD(reg_d),
    .gnt(gnt2), .select_x(sx2), .select_y(sy2), .bus_valid(bv2), .out(out2)
  );

  function automatic logic [3:0] model_out(input logic [3:0] g);
    case (g)
      4'b0001: return reg_a;
      4'b0010: return reg_b;
      4'b0100: return reg_c;
      4'b1000: return reg_d;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [1:0] model_idx(input logic [3:0] g);
    case (g)
      4'b0010: return 2'd1;
      4'b0100: return 2'd2;
      4'b1000: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  task automatic chk(input string nm, input int w, input logic [3:0] got, input logic [3:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s (dut MAX_BURST=%0d): got %b, expected %b", nm, w, got, want);
    end
  endtask

  task automatic check_dut(input string nm, input int w, input logic [3:0] g, input logic sx,
                           input logic sy, input logic bv, input logic [3:0] o,
                           input logic [3:0] eg, input logic [3:0] eo);
    chk({nm, " gnt"}, w, g, eg);
    chk({nm, " sel"}, w, 4'({sx, sy}), 4'(model_idx(eg)));
    chk({nm, " bus_valid"}, w, 4'(bv), 4'(eg != 4'b0000));
    chk({nm, " out"}, w, o, eo);
    chk({nm, " gnt_onehot"}, w, 4'($countones(g) > 1), 4'd0);
    chk({nm, " valid_vs_gnt"}, w, 4'(bv), 4'(g != 4'b0000));
  endtask

  // Drive one cycle of stimulus and queue the response expected after the next rising edge.
  task automatic cyc(input logic rst, input logic [3:0] r, input logic [3:0] g4,
                     input logic [3:0] g2, input string nm);
    exp_t e;
    @(negedge clk);
    reset = rst;
    req   = r;
    e.g4 = g4;
    e.o4 = model_out(g4);
    e.g2 = g2;
    e.o2 = model_out(g2);
    e.nm = nm;
    sb.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check_dut(e.nm, 4, gnt4, sx4, sy4, bv4, out4, e.g4, e.o4);
        check_dut(e.nm, 2, gnt2, sx2, sy2, bv2, out2, e.g2, e.o2);
      end
    end
  end

  initial begin : stimulus
    logic [3:0] g4, g2;
    int guard;
    cyc(1'b1, 4'b0000, 4'b0000, 4'b0000, "reset");
    cyc(1'b1, 4'b0000, 4'b0000, 4'b0000, "reset");

    // Single requester A for three cycles, then drop to idle.
    for (int k = 0; k < 3; k++) cyc(1'b0, 4'b0001, 4'b0001, 4'b0001, "single_a");
    cyc(1'b0, 4'b0000, 4'b0000, 4'b0000, "single_a_drop");
    cyc(1'b0, 4'b0000, 4'b0000, 4'b0000, "idle");

    // All four requesting: rotate A..D with each instance's burst length.
    cyc(1'b1, 4'b1111, 4'b0000, 4'b0000, "reset_rr");
    for (int k = 0; k < 20; k++) begin
      g4 = 4'b0001 << ((k / 4) % 4);
      g2 = 4'b0001 << ((k / 2) % 4);
      cyc(1'b0, 4'b1111, g4, g2, "rr_all");
    end

    // Holder B drops while A and D raise: D wins, then A, then D again.
    cyc(1'b1, 4'b0000, 4'b0000, 4'b0000, "reset");
    cyc(1'b0, 4'b0010, 4'b0010, 4'b0010, "hold_b");
    cyc(1'b0, 4'b0010, 4'b0010, 4'b0010, "hold_b");
    for (int k = 0; k < 10; k++) begin
      g4 = (k < 4 || k >= 8) ? 4'b1000 : 4'b0001;
      g2 = ((k / 2) % 2 == 0) ? 4'b1000 : 4'b0001;
      cyc(1'b0, 4'b1001, g4, g2, "b_to_d_a");
    end

    // Reset while D holds, then A has first priority.
    cyc(1'b1, 4'b1001, 4'b0000, 4'b0000, "reset_mid_xfer");
    cyc(1'b0, 4'b1111, 4'b0001, 4'b0001, "after_reset_a");
    cyc(1'b0, 4'b1111, 4'b0001, 4'b0001, "after_reset_a");
    cyc(1'b0, 4'b0000, 4'b0000, 4'b0000, "drop_all");

    // Lone requester C is re-granted across burst limits with no gap.
    cyc(1'b1, 4'b0000, 4'b0000, 4'b0000, "reset");
    for (int k = 0; k < 6; k++) cyc(1'b0, 4'b0100, 4'b0100, 4'b0100, "solo_c");
    cyc(1'b0, 4'b0000, 4'b0000, 4'b0000, "solo_c_drop");

    guard = 0;
    while (sb.size() > 0 && guard < 10) begin
      @(posedge clk);
      guard++;
    end
    #3;
    if (sb.size() > 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter MAX_BURST, default 4, SHALL set the maximum consecutive grant cycles per requester (legal range 1..15).
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 reset  input  1  SHALL be the synchronous, active-high reset.
REQ-004 req  input  4  SHALL carry per-requester bus requests; bit i = register source i (0=A, 1=B, 2=C, 3=D).
REQ-005 registerA, registerB, registerC, registerD  input  4 each  SHALL be the source register contents.
REQ-006 gnt  output  4  SHALL be the registered one-hot grant (all-zero when idle).
REQ-007 select_x  output  1  SHALL be the registered select MSB (s1) of the granted source.
REQ-008 select_y  output  1  SHALL be the registered select LSB (s0) of the granted source.
REQ-009 bus_valid  output  1  SHALL be high exactly when gnt is non-zero.
REQ-010 out  output  4  SHALL be the bus value: selected register when bus_valid, else 4'b0000.

Function
REQ-011 FSM SHALL have two states, IDLE and XFER; gnt non-zero only in XFER.
REQ-012 IDLE: any req bit high at edge n SHALL produce XFER with gnt set at edge n+1 (one-cycle grant latency).
REQ-013 Winner SHALL be chosen round-robin: first set req bit searching upward from (last_grant+1) mod 4.
REQ-014 {select_x, select_y} SHALL equal the binary index of the granted bit; held at 2'b00 when idle.
REQ-015 out SHALL be combinational from registered select and current register inputs: 00->A, 01->B, 10->C, 11->D.
REQ-016 Burst counter SHALL count grant cycles of the current holder, starting at 0 on each new grant.
REQ-017 Grant SHALL end after the cycle in which holder's req is low, or the burst counter reaches MAX_BURST-1.
REQ-018 At grant end, if any req high (holder excluded when burst-limited), next grant SHALL start next cycle, no idle gap.
REQ-019 At burst-limit end with holder as the only requester, holder SHALL be re-granted next cycle with counter cleared.
REQ-020 At grant end with no eligible req, FSM SHALL return to IDLE; gnt, bus_valid, out go to zero the next cycle.
REQ-021 last_grant SHALL update to the granted index on every new grant.
REQ-022 req changes on non-holder bits during XFER SHALL NOT affect the current grant.
REQ-023 gnt SHALL never have more than one bit set in any cycle.

Reset
REQ-024 reset at any edge, including mid-XFER, SHALL force IDLE, gnt=0, select_x=0, select_y=0, bus_valid=0, burst counter=0.
REQ-025 Reset SHALL set last_grant=3 so requester 0 (A) has first priority after reset.
REQ-026 out SHALL read 4'b0000 while reset is asserted and the cycle after.

Structure
REQ-027 Shared package SHALL hold the FSM state type, NUM_SRC=4, source-index constants SRC_A..SRC_D, and burst-counter width.
REQ-028 The round-robin search SHALL be one combinational sub-module, rr_picker (req, last_grant -> one-hot winner, index, any).
REQ-029 out SHALL be produced by the team's existing 4x1 gate-level mux per bit, gated by bus_valid.

Verification
REQ-030 reset, then req=4'b0001 held 3 cycles then dropped -> gnt=0001 one cycle after req, sel=00, out=registerA, IDLE after drop.
REQ-031 A=1,B=2,C=4,D=8, req=4'b1111 held, MAX_BURST=4 -> gnt 0001,0010,0100,1000 each 4 cycles, out 1,2,4,8, repeating.
REQ-032 req=4'b0100 held alone, MAX_BURST=2 -> gnt=0100 continuous, burst counter 0,1,0,1, no idle gap.
REQ-033 holder B, req drops 0010->1001 same edge -> next grant D (search from C), then A; no overlap of grant bits.
REQ-034 reset asserted during XFER with gnt=1000 -> next cycle gnt=0, sel=00, bus_valid=0, out=0; then req=4'b1111 grants A first.
REQ-035 every scenario: checker asserts gnt one-hot-or-zero and bus_valid==(gnt!=0) each cycle.
